divider: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage, the inverse partner of the combinational multiplier. It accepts a dividend/divisor pair on a start pulse and runs a radix-2 restoring iteration, one quotient bit per cycle. It returns quotient and remainder with a one-cycle valid pulse after a fixed latency. The execute stage stalls on `busy` and may abort an in-flight divide with `flush`.

---
 rtl/divider_if.sv | 22 ++
 rtl/divider.sv | 145 ++++++++++++++
 tb/tb_divider.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Handshake and operand/result bundle between the execute stage and the divider.
interface divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic             flush;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, flush, sign, dividend, divisor,
    input  busy, valid, quotient, remainder
  );

  modport slave (
    input  start, flush, sign, dividend, divisor,
    output busy, valid, quotient, remainder
  );
endinterface

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN to honour the sign input; otherwise all divides are unsigned.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | 32 shift/subtract iterations
// DONE  | first cycle registers results and raises valid, second returns to IDLE
module divider #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [4:0]         count;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               busy_q;
  logic               valid_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   q_final;
  logic [WIDTH-1:0]   r_final;

`ifdef DIVIDER_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic neg_q;
  logic neg_r;
  logic div_zero;

  assign neg_a = bus.sign & bus.dividend[WIDTH-1];
  assign neg_b = bus.sign & bus.divisor[WIDTH-1];
  assign a_abs = neg_a ? -bus.dividend : bus.dividend;
  assign b_abs = neg_b ? -bus.divisor  : bus.divisor;

  // Overflow (MIN / -1) falls out naturally: |MIN| / 1 = MIN, and negating MIN is MIN.
  always_comb begin
    q_final = neg_q ? -quo : quo;
    r_final = neg_r ? -rem : rem;
    if (div_zero) q_final = '1;
  end
`else
  logic sign_unused;

  assign sign_unused = bus.sign;
  assign a_abs       = bus.dividend;
  assign b_abs       = bus.divisor;

  // A zero divisor naturally yields all-ones quotient and remainder = dividend.
  always_comb begin
    q_final = quo;
    r_final = rem;
  end
`endif

  // Partial remainder can reach 2*divisor-1 after the shift, so compare in WIDTH+1 bits.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign ge      = ~diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_zero    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.start && !bus.flush) begin
            rem    <= '0;
            quo    <= a_abs;
            dvs    <= b_abs;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
`ifdef DIVIDER_SIGNED_EN
            neg_q    <= neg_a ^ neg_b;
            neg_r    <= neg_a;
            div_zero <= (bus.divisor == '0);
`endif
          end
        end
        CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            count  <= '0;
            state  <= IDLE;
          end else begin
            rem   <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], ge};
            count <= count + 5'd1;
            if (count == 5'd31) state <= DONE;
          end
        end
        DONE: begin
          if (!valid_q) begin
            quotient_q  <= q_final;
            remainder_q <= r_final;
            valid_q     <= 1'b1;
          end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            count   <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed scenarios plus random pairs against a reference model.
module tb_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  divider_if #(.WIDTH(32)) dif ();

  divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  // Reference: integer semantics straight from the rules, not the iteration.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    logic sg_eff;
`ifdef DIVIDER_SIGNED_EN
    sg_eff = sg;
`else
    sg_eff = 1'b0;
`endif
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sg_eff) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Issues a start in the current IDLE cycle and waits for valid; lat counts negedges after accept.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    dif.dividend = a;
    dif.divisor  = b;
    dif.sign     = sg;
    dif.start    = 1'b1;
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = $urandom;
    dif.divisor  = $urandom;
    lat     = 1;
    busy_ok = dif.busy;
    while (!dif.valid && lat < 100) begin
      @(negedge clk);
      lat++;
      busy_ok = busy_ok & dif.busy;
    end
    q = dif.quotient;
    r = dif.remainder;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sg);
    logic [31:0] q, r, eq, er;
    int lat;
    logic bok;
    model(a, b, sg, eq, er);
    do_div(a, b, sg, q, r, lat, bok);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 34", name, lat);
    end
    checks++;
    if (q !== eq || r !== er) begin
      errors++;
      $display("FAIL %s result: got q=%h r=%h expected q=%h r=%h", name, q, r, eq, er);
    end
  endtask

  task automatic test_reset();
    dif.start = 1'b0; dif.flush = 1'b0; dif.sign = 1'b0;
    dif.dividend = '0; dif.divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0 || dif.valid !== 1'b0 || dif.quotient !== 32'd0 || dif.remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b valid=%b q=%h r=%h expected all zero",
               dif.busy, dif.valid, dif.quotient, dif.remainder);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r;
    int lat;
    logic bok;
    do_div(32'd100, 32'd7, 1'b0, q, r, lat, bok);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL unsigned_latency: got %0d expected 34", lat);
    end
    checks++;
    if (q !== 32'd14 || r !== 32'd2) begin
      errors++;
      $display("FAIL unsigned_100_7: got q=%0d r=%0d expected q=14 r=2", q, r);
    end
    checks++;
    if (bok !== 1'b1) begin
      errors++;
      $display("FAIL unsigned_busy_high: busy dropped before valid");
    end
    @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0 || dif.valid !== 1'b0 || dif.quotient !== 32'd14) begin
      errors++;
      $display("FAIL unsigned_after_valid: busy=%b valid=%b q=%0d expected busy=0 valid=0 q=14",
               dif.busy, dif.valid, dif.quotient);
    end
  endtask

  task automatic test_div_zero();
    check_op("div_zero", 32'h1234_5678, 32'd0, 1'b0);
  endtask

  task automatic test_signed();
`ifdef DIVIDER_SIGNED_EN
    check_op("signed_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    check_op("signed_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check_op("signed_div_zero", 32'hFFFF_FFFB, 32'd0, 1'b1);
    check_op("signed_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
`else
    logic [31:0] q, r;
    int lat;
    logic bok;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, lat, bok);
    checks++;
    if (q !== 32'h7FFF_FFFC || r !== 32'd1) begin
      errors++;
      $display("FAIL sign_ignored_m7_2: got q=%h r=%h expected q=7ffffffc r=00000001", q, r);
    end
`endif
  endtask

  task automatic test_flush();
    logic [31:0] pq, pr;
    logic saw_valid;
    pq = dif.quotient;
    pr = dif.remainder;
    @(negedge clk);
    dif.dividend = 32'd50; dif.divisor = 32'd5; dif.sign = 1'b0; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (8) @(negedge clk);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got busy=%b expected 0", dif.busy);
    end
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_valid = saw_valid | dif.valid;
    end
    checks++;
    if (saw_valid !== 1'b0 || dif.quotient !== pq || dif.remainder !== pr) begin
      errors++;
      $display("FAIL flush_no_result: valid_seen=%b q=%h r=%h expected valid_seen=0 q=%h r=%h",
               saw_valid, dif.quotient, dif.remainder, pq, pr);
    end
    // start and flush together in IDLE: nothing accepted
    dif.dividend = 32'd9; dif.divisor = 32'd3; dif.start = 1'b1; dif.flush = 1'b1;
    @(negedge clk);
    dif.start = 1'b0; dif.flush = 1'b0;
    checks++;
    if (dif.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_beats_start: got busy=%b expected 0", dif.busy);
    end
  endtask

  task automatic test_busy_start();
    int lat;
    @(negedge clk);
    dif.dividend = 32'd1000; dif.divisor = 32'd10; dif.sign = 1'b0; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    lat = 1;
    while (!dif.valid && lat < 100) begin
      if (lat == 5) begin
        dif.dividend = 32'd9; dif.divisor = 32'd3; dif.start = 1'b1;
      end else begin
        dif.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    dif.start = 1'b0;
    checks++;
    if (lat !== 34 || dif.quotient !== 32'd100 || dif.remainder !== 32'd0) begin
      errors++;
      $display("FAIL busy_start_ignored: lat=%0d q=%0d r=%0d expected lat=34 q=100 r=0",
               lat, dif.quotient, dif.remainder);
    end
  endtask

  task automatic test_async_reset();
    logic saw_valid;
    @(negedge clk);
    dif.dividend = 32'd77; dif.divisor = 32'd3; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dif.busy !== 1'b0 || dif.valid !== 1'b0 || dif.quotient !== 32'd0 || dif.remainder !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b q=%h r=%h expected all zero",
               dif.busy, dif.valid, dif.quotient, dif.remainder);
    end
    #1 rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_valid = saw_valid | dif.valid | dif.busy;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_quiet: busy or valid seen after reset, expected none");
    end
    check_op("after_reset_100_7", 32'd100, 32'd7, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = b >> ($urandom_range(31, 0));
      if (b == 32'd0) b = 32'd1;
`ifdef DIVIDER_SIGNED_EN
      check_op("random_unsigned", a, b, 1'b0);
`else
      check_op("random_unsigned", a, b, 1'($urandom_range(1, 0)));
`endif
    end
`ifdef DIVIDER_SIGNED_EN
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = $urandom >> ($urandom_range(31, 0));
      if (i % 2 == 0) b = -b;
      check_op("random_signed", a, b, 1'b1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_flush();
    test_busy_start();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
